// File: rtl/pipeline_pkg.sv
// Shared stage-boundary types for the core pipeline.
// Each boundary has a packed control struct, a packed datapath struct,
// their bit widths, and the control value that represents a bubble.
package pipeline_pkg;

  // Execute -> Memory control bits (write enables first)
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic branch;
    logic jump;
    logic alu_src;
    logic halt;
  } execute_memory_ctrl_t;

  // Execute -> Memory datapath fields
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        zero;
  } execute_memory_data_t;

  // Memory -> Writeback control bits
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic halt;
  } memory_writeback_ctrl_t;

  // Memory -> Writeback datapath fields
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [4:0]  rd;
  } memory_writeback_data_t;

  localparam int EX_MEM_CTRL_W = $bits(execute_memory_ctrl_t);
  localparam int EX_MEM_DATA_W = $bits(execute_memory_data_t);
  localparam int MEM_WB_CTRL_W = $bits(memory_writeback_ctrl_t);
  localparam int MEM_WB_DATA_W = $bits(memory_writeback_data_t);

  // A bubble must never carry a write enable into a later stage
  localparam execute_memory_ctrl_t   EX_MEM_CTRL_BUBBLE = '0;
  localparam memory_writeback_ctrl_t MEM_WB_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipeline_slot.sv
// One storage entry of a stage register: control, datapath and valid.
// Priority: reset > clear > load > drop. Clear only kills the valid bit,
// stored ctrl/data are kept.
module pipeline_slot #(
  parameter int CTRL_WIDTH = 8,
  parameter int DATA_WIDTH = 134
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  drop,
  input  logic [CTRL_WIDTH-1:0] ctrl_d,
  input  logic [DATA_WIDTH-1:0] data_d,
  output logic                  vld,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  vld_p1;
  logic [CTRL_WIDTH-1:0] ctrl_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  // Entry register: load captures a beat, drop empties, clear kills valid only
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end else if (clear) begin
      vld_p1  <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      ctrl_p1 <= ctrl_d;
      data_p1 <= data_d;
    end else if (drop) begin
      vld_p1  <= 1'b0;
    end
  end

  assign vld  = vld_p1;
  assign ctrl = ctrl_p1;
  assign data = data_p1;

endmodule

// File: rtl/pipeline_stage_register.sv
// Generic valid/ready stage register between two pipeline stages.
// Control bits are masked to CTRL_BUBBLE whenever no valid beat is held.
// Build option: define PIPELINE_STAGE_SKID_BUFFER_EN to add a skid slot,
// which registers in_ready (no combinational path from out_ready).
module pipeline_stage_register
  import pipeline_pkg::*;
#(
  parameter int                    CTRL_WIDTH  = EX_MEM_CTRL_W,
  parameter int                    DATA_WIDTH  = EX_MEM_DATA_W,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data
);

  // Replace control with the bubble pattern when the entry is empty
  function automatic logic [CTRL_WIDTH-1:0] mask_ctrl(
    input logic                  vld,
    input logic [CTRL_WIDTH-1:0] ctrl
  );
    return vld ? ctrl : CTRL_BUBBLE;
  endfunction

  logic                  accept;
  logic                  main_load;
  logic                  main_drop;
  logic [CTRL_WIDTH-1:0] main_ctrl_d;
  logic [DATA_WIDTH-1:0] main_data_d;
  logic                  main_vld_p1;
  logic [CTRL_WIDTH-1:0] main_ctrl_p1;
  logic [DATA_WIDTH-1:0] main_data_p1;

`ifdef PIPELINE_STAGE_SKID_BUFFER_EN

  logic                  main_free;
  logic                  skid_load;
  logic                  skid_drop;
  logic                  skid_vld_p1;
  logic [CTRL_WIDTH-1:0] skid_ctrl_p1;
  logic [DATA_WIDTH-1:0] skid_data_p1;

  // Main refills from skid first; new beats land in skid only while main stalls.
  // in_ready comes straight from the skid valid flop.
  always_comb begin
    in_ready    = ~skid_vld_p1;
    accept      = in_valid & in_ready;
    main_free   = ~main_vld_p1 | out_ready;
    main_load   = main_free & (skid_vld_p1 | accept);
    main_drop   = main_free & ~skid_vld_p1 & ~accept;
    main_ctrl_d = skid_vld_p1 ? skid_ctrl_p1 : in_ctrl;
    main_data_d = skid_vld_p1 ? skid_data_p1 : in_data;
    skid_load   = accept & ~main_free;
    skid_drop   = main_free & skid_vld_p1;
  end

  // ---- skid slot (second entry, holds the beat accepted during a stall) ----
  pipeline_slot #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_slot (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (skid_load),
    .drop   (skid_drop),
    .ctrl_d (in_ctrl),
    .data_d (in_data),
    .vld    (skid_vld_p1),
    .ctrl   (skid_ctrl_p1),
    .data   (skid_data_p1)
  );

`else

  // Single slot: can take a beat when empty or when its beat leaves this cycle
  always_comb begin
    in_ready    = ~main_vld_p1 | out_ready;
    accept      = in_valid & in_ready;
    main_load   = accept;
    main_drop   = in_ready & ~in_valid;
    main_ctrl_d = in_ctrl;
    main_data_d = in_data;
  end

`endif

  // ---- main slot (drives the downstream stage) ----
  pipeline_slot #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_main_slot (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (main_load),
    .drop   (main_drop),
    .ctrl_d (main_ctrl_d),
    .data_d (main_data_d),
    .vld    (main_vld_p1),
    .ctrl   (main_ctrl_p1),
    .data   (main_data_p1)
  );

  assign out_valid = main_vld_p1;
  assign out_ctrl  = mask_ctrl(main_vld_p1, main_ctrl_p1);
  assign out_data  = main_data_p1;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register: directed scenarios followed by
// randomized traffic, all checked against a queue model of held beats.
module tb_pipeline_stage_register;

  localparam int             CW  = 8;
  localparam int             DW  = 134;
  localparam logic [CW-1:0]  BUB = 8'h00;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;

  pipeline_stage_register #(
    .CTRL_WIDTH  (CW),
    .DATA_WIDTH  (DW),
    .CTRL_BUBBLE (BUB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  // Beats currently held by the stage, oldest first
  beat_t q[$];
  int    checks;
  int    errors;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Stage can take a beat: base holds one (or frees it this cycle), skid holds two
  function automatic logic model_ready(input logic ordy);
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || ordy;
`endif
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] x;
    x = '0;
    for (int k = 0; k < 5; k++) x = {x[DW-33:0], 32'($urandom())};
    return x;
  endfunction

  // One clock: drive inputs, check outputs against model, advance model at the edge
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic r, input logic f, input logic rs);
    logic exp_rdy;
    @(negedge clk);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    flush    = f;
    reset    = rs;
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
    begin
      logic a, b;
      out_ready = 1'b0;
      #1 a = in_ready;
      out_ready = 1'b1;
      #1 b = in_ready;
      check("in_ready_indep", {{(DW-1){1'b0}}, b}, {{(DW-1){1'b0}}, a});
    end
`endif
    out_ready = r;
    #1;
    exp_rdy = model_ready(r);
    check("in_ready", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, exp_rdy});
    check("out_valid", {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, (q.size() > 0)});
    check("out_ctrl", {{(DW-CW){1'b0}}, out_ctrl},
          {{(DW-CW){1'b0}}, ((q.size() > 0) ? q[0].c : BUB)});
    if (q.size() > 0) check("out_data", out_data, q[0].d);
    @(posedge clk);
    if (rs || f) begin
      q.delete();
    end else begin
      if (q.size() > 0 && r) void'(q.pop_front());
      if (v && exp_rdy) q.push_back('{c: c, d: d});
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'hFF;
    in_data   = rand_data();
    out_ready = 1'b1;

    // Reset held two cycles with a valid beat offered
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {{(DW-1){1'b0}}, out_valid}, '0);
    check("rst_ctrl", {{(DW-CW){1'b0}}, out_ctrl}, {{(DW-CW){1'b0}}, BUB});
    check("rst_data", out_data, '0);
    q.delete();

    // First beat after release, then a 10-beat stream
    step(1'b1, 8'h11, 134'hA5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, CW'(i), DW'(i), 1'b1, 1'b0, 1'b0);

    // Bubble masking: no valid input, all-ones control offered
    repeat (3) step(1'b0, 8'hFF, '0, 1'b1, 1'b0, 1'b0);

    // Stall with DEADBEEF held while another beat is offered
    step(1'b1, 8'h5A, 134'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h5B, 134'hCAFEF00D, 1'b0, 1'b0, 1'b0);
      #1 check("stall_hold", out_data, 134'hDEADBEEF);
    end
    repeat (3) step(1'b0, 8'hFF, '0, 1'b1, 1'b0, 1'b0);

    // Flush with a held beat and a simultaneous new offer
    step(1'b1, 8'h77, 134'h1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h78, 134'h2222, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h79, 134'h3333, 1'b0, 1'b1, 1'b0);
    #1 check("flush_ctrl", {{(DW-CW){1'b0}}, out_ctrl}, {{(DW-CW){1'b0}}, BUB});
    repeat (3) step(1'b0, 8'hFF, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 10000; n++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom()), rand_data(),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 999) < 3));
    end
    repeat (3) step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
